// File: rtl/saw_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : saw_seq_pkg
// Description : Shared types and constants for the sawtooth step sequencer:
//               FSM state encoding, Scale width, step-table entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package saw_seq_pkg;

    // Width of the generator Scale bus.
    localparam int SCALE_W = 6;

    // Storage width of the duration field inside a table entry. The sequencer
    // zero-extends its DUR_W-bit duration into this field, so DUR_W may be
    // anything up to this value.
    localparam int MAX_DUR_W = 32;

    // Default table depth and the index width it implies.
    localparam int DEF_STEPS = 8;
    localparam int DEF_IDX_W = $clog2(DEF_STEPS);

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    // One step-table entry.
    typedef struct packed {
        logic [SCALE_W-1:0]   scale;
        logic [MAX_DUR_W-1:0] dur;
    } step_entry_t;

    // Index width for a table of the given depth (at least one bit).
    function automatic int idx_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/saw_tick_divider.sv
`default_nettype none
// ============================================================================
// Module      : saw_tick_divider
// Description : Divides the system clock down to a one-cycle tick every
//               TICK_DIV cycles. A synchronous clear restarts the count so the
//               first tick arrives exactly TICK_DIV cycles after the clear.
// Revision    : 1.0 - initial release
// ============================================================================
module saw_tick_divider #(
    parameter int TICK_DIV = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_count;

    // Free-running modulo-TICK_DIV counter, restarted by clear.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (r_count == C_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tick = (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/saw_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : saw_step_sequencer
// Description : Plays a programmed table of {Scale, duration} steps on the
//               sawtooth generator's Scale / Enable_SW_1 inputs, with optional
//               looping, abort, and an end-of-playback Done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module saw_step_sequencer
    import saw_seq_pkg::*;
#(
    parameter  int STEPS    = 8,
    parameter  int DUR_W    = 16,
    parameter  int TICK_DIV = 64,
    localparam int IDX_W    = idx_width(STEPS)
) (
    input  logic               sysclk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Stop,
    input  logic               Loop,
    input  logic               Wr_En,
    input  logic [IDX_W-1:0]   Wr_Addr,
    input  logic [SCALE_W-1:0] Wr_Scale,
    input  logic [DUR_W-1:0]   Wr_Dur,
    output logic               Wr_Ready,
    output logic [SCALE_W-1:0] Scale,
    output logic               Enable_SW_1,
    output logic               Busy,
    output logic [IDX_W-1:0]   Step_Index,
    output logic               Done
);

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(STEPS - 1);
    localparam logic [DUR_W-1:0] C_DUR_ONE  = DUR_W'(1);

    seq_state_t         r_state;
    seq_state_t         w_next;
    step_entry_t        r_table [STEPS];
    logic [IDX_W-1:0]   r_index;
    logic               r_wrapped;     // index rolled past STEPS-1 since step 0
    logic [DUR_W-1:0]   r_remaining;
    logic [SCALE_W-1:0] r_scale;
    logic               r_enable;

    step_entry_t        w_entry;
    logic               w_end;
    logic               w_restart;
    logic               w_div_clear;
    logic               w_tick;

    assign w_entry = r_table[r_index];

    // End of pattern: a zero-duration marker, or the whole table has been played.
    assign w_end = (w_entry.dur == '0) || r_wrapped;

    // Loop back to step 0 only if we actually advanced; an empty table ends.
    assign w_restart = w_end && Loop && ((r_index != '0) || r_wrapped);

    saw_tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk     (sysclk),
        .rst     (Reset),
        .i_clear (w_div_clear),
        .o_tick  (w_tick)
    );

    // Next-state logic; Stop overrides everything while playing.
    always_comb begin
        w_next      = r_state;
        w_div_clear = 1'b0;
        case (r_state)
            IDLE: begin
                if (Start && !Stop) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                if (Stop) begin
                    w_next = DONE;
                end else if (!w_end) begin
                    w_next      = PLAY;
                    w_div_clear = 1'b1;
                end else if (!w_restart) begin
                    w_next = DONE;
                end
            end
            PLAY: begin
                if (Stop) begin
                    w_next = DONE;
                end else if (w_tick && (r_remaining == C_DUR_ONE)) begin
                    w_next = LOAD;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State register and playback datapath (index, remaining ticks, outputs).
    always_ff @(posedge sysclk) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_index     <= '0;
            r_wrapped   <= 1'b0;
            r_remaining <= '0;
            r_scale     <= '0;
            r_enable    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == DONE) begin
                // Silence the generator as Done asserts.
                r_scale   <= '0;
                r_enable  <= 1'b0;
                r_index   <= '0;
                r_wrapped <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_next == LOAD) begin
                            r_index   <= '0;
                            r_wrapped <= 1'b0;
                        end
                    end
                    LOAD: begin
                        if (w_next == PLAY) begin
                            r_scale     <= w_entry.scale;
                            r_enable    <= (w_entry.scale != '0);
                            r_remaining <= w_entry.dur[DUR_W-1:0];
                        end else if (w_restart) begin
                            r_index   <= '0;
                            r_wrapped <= 1'b0;
                        end
                    end
                    PLAY: begin
                        if (w_tick) begin
                            r_remaining <= r_remaining - 1'b1;
                            if (w_next == LOAD) begin
                                r_index <= r_index + 1'b1;
                                if (r_index == C_LAST_IDX) begin
                                    r_wrapped <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Step table: written only while idle, cleared by reset.
    always_ff @(posedge sysclk) begin
        if (Reset) begin
            for (int i = 0; i < STEPS; i++) begin
                r_table[i] <= '0;
            end
        end else if ((r_state == IDLE) && Wr_En) begin
            r_table[Wr_Addr] <= '{scale: Wr_Scale, dur: MAX_DUR_W'(Wr_Dur)};
        end
    end

    assign Wr_Ready    = (r_state == IDLE);
    assign Busy        = (r_state == LOAD) || (r_state == PLAY);
    assign Done        = (r_state == DONE);
    assign Scale       = r_scale;
    assign Enable_SW_1 = r_enable;
    assign Step_Index  = r_index;

endmodule
`default_nettype wire

// File: tb/tb_saw_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_saw_step_sequencer
// Description : Self-checking bench for saw_step_sequencer. A reference model
//               unrolls the step table into the expected per-cycle output
//               trace, which is compared against the DUT every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_saw_step_sequencer;

    localparam int STEPS = 8;
    localparam int DUR_W = 16;
    localparam int TD    = 4;
    localparam int IW    = 3;

    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       done;
        logic       en;
        logic [5:0] scale;
        logic [2:0] idx;
    } obs_t;

    logic             sysclk = 1'b0;
    logic             Reset = 1'b1;
    logic             Start = 1'b0;
    logic             Stop = 1'b0;
    logic             Loop = 1'b0;
    logic             Wr_En = 1'b0;
    logic [IW-1:0]    Wr_Addr = '0;
    logic [5:0]       Wr_Scale = '0;
    logic [DUR_W-1:0] Wr_Dur = '0;
    logic             Wr_Ready;
    logic [5:0]       Scale;
    logic             Enable_SW_1;
    logic             Busy;
    logic [IW-1:0]    Step_Index;
    logic             Done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference table and expected trace.
    logic [5:0] m_scale [STEPS];
    int         m_dur   [STEPS];
    obs_t       exp_q[$];
    obs_t       c_idle_obs;

    saw_step_sequencer #(
        .STEPS    (STEPS),
        .DUR_W    (DUR_W),
        .TICK_DIV (TD)
    ) dut (
        .sysclk      (sysclk),
        .Reset       (Reset),
        .Start       (Start),
        .Stop        (Stop),
        .Loop        (Loop),
        .Wr_En       (Wr_En),
        .Wr_Addr     (Wr_Addr),
        .Wr_Scale    (Wr_Scale),
        .Wr_Dur      (Wr_Dur),
        .Wr_Ready    (Wr_Ready),
        .Scale       (Scale),
        .Enable_SW_1 (Enable_SW_1),
        .Busy        (Busy),
        .Step_Index  (Step_Index),
        .Done        (Done)
    );

    always #5 sysclk = ~sysclk;

    function automatic obs_t dut_obs();
        obs_t o;
        o.ready = Wr_Ready;
        o.busy  = Busy;
        o.done  = Done;
        o.en    = Enable_SW_1;
        o.scale = Scale;
        o.idx   = Step_Index;
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < STEPS; i++) begin
            m_scale[i] = '0;
            m_dur[i]   = 0;
        end
    endtask

    // Table write while idle; the model records it too.
    task automatic write_entry(input int addr, input logic [5:0] sc, input int dur);
        Wr_En    = 1'b1;
        Wr_Addr  = IW'(addr);
        Wr_Scale = sc;
        Wr_Dur   = DUR_W'(dur);
        @(negedge sysclk);
        Wr_En = 1'b0;
        m_scale[addr] = sc;
        m_dur[addr]   = dur;
    endtask

    // Append one busy-cycle sample; report whether Stop lands on it.
    task automatic emit(input logic [5:0] sc, input int idx, input int stop_at, output bit hit);
        obs_t o;
        o.ready = 1'b0;
        o.busy  = 1'b1;
        o.done  = 1'b0;
        o.en    = (sc != '0);
        o.scale = sc;
        o.idx   = 3'(idx);
        exp_q.push_back(o);
        hit = ((exp_q.size() - 1) == stop_at);
    endtask

    // Unroll the table into expected samples. Sample k is taken after the
    // k-th edge following the Start edge; Loop seen in sample k is (k < loop_off),
    // and Stop is asserted during sample stop_at.
    task automatic build_trace(input int loop_off, input int stop_at);
        int         idx;
        bit         wrapped;
        bit         hit;
        bit         fin;
        logic [5:0] hs;
        obs_t       o;
        idx = 0; wrapped = 0; hit = 0; fin = 0; hs = '0;
        exp_q.delete();
        while (!fin && !hit) begin
            emit(hs, idx, stop_at, hit);                       // table read cycle
            if (!hit) begin
                if (m_dur[idx] == 0 || wrapped) begin
                    if (((exp_q.size() - 1) < loop_off) && (idx != 0 || wrapped)) begin
                        idx = 0; wrapped = 0;
                    end else begin
                        fin = 1;
                    end
                end else begin
                    hs = m_scale[idx];
                    for (int c = 0; c < m_dur[idx] * TD && !hit; c++) begin
                        emit(hs, idx, stop_at, hit);
                    end
                    idx = idx + 1;
                    if (idx == STEPS) begin
                        idx = 0; wrapped = 1;
                    end
                end
            end
            if (exp_q.size() > 3000) fin = 1;
        end
        o = '0; o.done = 1'b1;
        exp_q.push_back(o);
        exp_q.push_back(c_idle_obs);
    endtask

    // Start a run from idle and compare every cycle until back in idle.
    task automatic run(input string name, input int loop_off, input int stop_at,
                       input int start_at, input int wr_at);
        int last;
        build_trace(loop_off, stop_at);
        last  = exp_q.size() - 2;
        Start = 1'b1; Stop = 1'b0; Loop = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge sysclk);
            check($sformatf("%s[%0d]", name, k), 32'(dut_obs()), 32'(exp_q[k]));
            Start    = (k == start_at) && (k <= last);
            Stop     = (k == stop_at);
            Loop     = (k < loop_off);
            Wr_En    = (k == wr_at) && (k <= last);
            Wr_Addr  = '0;
            Wr_Scale = 6'd63;
            Wr_Dur   = DUR_W'(5);
        end
        Start = 1'b0; Stop = 1'b0; Loop = 1'b0; Wr_En = 1'b0;
    endtask

    initial begin
        c_idle_obs = '0;
        c_idle_obs.ready = 1'b1;
        model_clear();

        // Reset and quiet idle.
        repeat (3) @(negedge sysclk);
        check("reset_held", 32'(dut_obs()), 32'(c_idle_obs));
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge sysclk);
            check($sformatf("idle[%0d]", k), 32'(dut_obs()), 32'(c_idle_obs));
        end

        // Directed pattern: 10 for 2 ticks, rest 1 tick, 20 for 1 tick, marker.
        write_entry(0, 6'd10, 2);
        write_entry(1, 6'd0, 1);
        write_entry(2, 6'd20, 1);
        write_entry(3, 6'($urandom_range(0, 63)), 0);
        run("basic", 0, -1, -1, -1);

        // Same table looping once, then Loop drops.
        run("loop", 30, -1, -1, -1);

        // Start and Stop together from idle: nothing happens.
        Start = 1'b1; Stop = 1'b1;
        @(negedge sysclk);
        Start = 1'b0; Stop = 1'b0;
        check("start_stop_idle", 32'(dut_obs()), 32'(c_idle_obs));
        @(negedge sysclk);
        check("start_stop_idle2", 32'(dut_obs()), 32'(c_idle_obs));

        // Stop in the middle of the first step.
        run("stop_play", 0, 5, -1, -1);

        // Ignored write while playing and ignored Start while busy; then replay.
        run("busy_wr", 0, -1, 4, 3);
        run("replay", 0, -1, -1, -1);

        // Random tables, loop lengths, stops and busy-time pokes.
        for (int it = 0; it < 12; it++) begin
            for (int a = 0; a < STEPS; a++) begin
                int         d;
                logic [5:0] s;
                d = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 3));
                s = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
                write_entry(a, s, d);
            end
            run($sformatf("rnd%0d", it),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 200)) : 0,
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 120)) : -1,
                int'($urandom_range(1, 60)),
                int'($urandom_range(1, 60)));
        end

        // Reset mid-playback: immediate idle, no Done, table cleared.
        Start = 1'b1;
        @(negedge sysclk);
        Start = 1'b0;
        repeat (6) @(negedge sysclk);
        Reset = 1'b1;
        @(negedge sysclk);
        check("reset_mid_play", 32'(dut_obs()), 32'(c_idle_obs));
        Reset = 1'b0;
        model_clear();
        @(negedge sysclk);
        check("after_reset", 32'(dut_obs()), 32'(c_idle_obs));

        // Empty table with Loop held high must still end.
        run("empty_loop", 1000, -1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
